// File: rtl/tristate_bus_arbiter.sv
// Arbiter and enable generator for a shared tristate bus: one owner at a time,
// a settle/capture phase, then a dead turnaround cycle before the next owner.
// Optional build macro: ROUND_ROBIN_EN (round-robin; fixed lowest-index priority otherwise).
module tristate_bus_arbiter #(
  parameter int NSRC = 4,
  parameter int DW   = 4,
  parameter int HOLD = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NSRC-1:0]          req,
  input  logic [DW-1:0]            bus_in,
  output logic [NSRC-1:0]          en,
  output logic [$clog2(NSRC)-1:0]  grant_id,
  output logic                     busy,
  output logic [DW-1:0]            rx_data,
  output logic                     rx_valid,
  output logic [1:0]               fsm_state
);

  localparam int GW = $clog2(NSRC);
  localparam logic [NSRC-1:0] ONE = NSRC'(1);

  // Handshake: req is a level, sampled only in IDLE; once granted the
  // transfer always runs DRIVE -> CAPTURE -> TURN, and rx_valid marks the
  // single cycle in which rx_data holds the newly captured value.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    TURN    = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [GW-1:0] win;

  assign fsm_state = state;

`ifdef ROUND_ROBIN_EN
  logic [GW-1:0] rr_ptr;

  // Search starts at rr_ptr and wraps, so the last owner is considered last.
  always_comb begin
    logic          found;
    logic [GW-1:0] idx;
    int            j;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NSRC; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NSRC) j = j - NSRC;
      idx = GW'(j);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (req[k]) win = GW'(k);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      en       <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      cnt      <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr   <= '0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant_id <= win;
            en       <= ONE << win;
            busy     <= 1'b1;
            cnt      <= 4'(HOLD - 1);
            state    <= DRIVE;
`ifdef ROUND_ROBIN_EN
            rr_ptr   <= (win == GW'(NSRC - 1)) ? '0 : win + GW'(1);
`endif
          end
        end
        DRIVE: begin
          if (cnt == 4'd0) state <= CAPTURE;
          else cnt <= cnt - 4'd1;
        end
        CAPTURE: begin
          // Enable drops here so TURN is a cycle with no driver on the bus.
          rx_data  <= bus_in;
          rx_valid <= 1'b1;
          en       <= '0;
          state    <= TURN;
        end
        TURN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          en    <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed bench for tristate_bus_arbiter: a HOLD=1 instance for the main
// sequence and a HOLD=3 instance for the extended settle case.
module tb_tristate_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req3;
  logic [3:0] bus, bus3;
  logic [3:0] en, en3;
  logic [1:0] grant_id, grant_id3;
  logic       busy, busy3;
  logic [3:0] rx_data, rx_data3;
  logic       rx_valid, rx_valid3;
  logic [1:0] fsm_state, fsm_state3;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  tristate_bus_arbiter #(.NSRC(4), .DW(4), .HOLD(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bus_in(bus), .en(en),
    .grant_id(grant_id), .busy(busy), .rx_data(rx_data),
    .rx_valid(rx_valid), .fsm_state(fsm_state)
  );

  tristate_bus_arbiter #(.NSRC(4), .DW(4), .HOLD(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .bus_in(bus3), .en(en3),
    .grant_id(grant_id3), .busy(busy3), .rx_data(rx_data3),
    .rx_valid(rx_valid3), .fsm_state(fsm_state3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] exp_t2 [4];
    logic [1:0] exp_t3 [5];
    logic [3:0] onehot;

`ifdef ROUND_ROBIN_EN
    exp_t2 = '{2'd1, 2'd3, 2'd1, 2'd3};
    exp_t3 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_t2 = '{2'd1, 2'd1, 2'd1, 2'd1};
    exp_t3 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif

    rst_n = 1'b0;
    req   = '0;
    req3  = '0;
    bus   = '0;
    bus3  = '0;
    step();
    step();
    check("rst_en", en, 4'b0000);
    check("rst_gid", grant_id, 2'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_rxd", rx_data, 4'h0);
    check("rst_rxv", rx_valid, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    rst_n = 1'b1;
    step();
    check("idle_noreq_en", en, 4'b0000);
    check("idle_noreq_busy", busy, 1'b0);

    // T1: single one-cycle request from source 2
    req = 4'b0100;
    bus = 4'hA;
    step();
    check("t1_en_grant", en, 4'b0100);
    check("t1_gid", grant_id, 2'd2);
    check("t1_busy", busy, 1'b1);
    check("t1_rxv_drive", rx_valid, 1'b0);
    req = 4'b0000;
    step();
    check("t1_en_capture", en, 4'b0100);
    check("t1_state_capture", fsm_state, 2'd2);
    check("t1_rxv_capture", rx_valid, 1'b0);
    step();
    check("t1_en_turn", en, 4'b0000);
    check("t1_rxv_turn", rx_valid, 1'b1);
    check("t1_rxd", rx_data, 4'hA);
    check("t1_busy_turn", busy, 1'b1);
    step();
    check("t1_rxv_after", rx_valid, 1'b0);
    check("t1_busy_after", busy, 1'b0);
    check("t1_gid_hold", grant_id, 2'd2);
    step();
    check("t1_rxv_idle", rx_valid, 1'b0);
    check("t1_en_idle", en, 4'b0000);

    // T2: two held requesters
    do_reset();
    req = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      step();
      onehot = 4'b0001 << exp_t2[g];
      check("t2_gid", grant_id, exp_t2[g]);
      check("t2_en", en, onehot);
      step();
      check("t2_en_capture", en, onehot);
      step();
      check("t2_en_turn", en, 4'b0000);
      step();
      check("t2_en_idle", en, 4'b0000);
    end

    // T3: all four held; one grant every HOLD+3 cycles, never overlapping
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      check("t3_gid", grant_id, exp_t3[g]);
      check("t3_onehot", en, 4'b0001 << exp_t3[g]);
      step();
      check("t3_onehot0", 32'($onehot0(en)), 32'd1);
      step();
      check("t3_turn_en", en, 4'b0000);
      step();
    end

    // T4: request dropped after one cycle still completes
    do_reset();
    req = 4'b0001;
    bus = 4'h5;
    step();
    check("t4_en", en, 4'b0001);
    req = 4'b0000;
    step();
    check("t4_en_capture", en, 4'b0001);
    step();
    check("t4_rxv", rx_valid, 1'b1);
    check("t4_rxd", rx_data, 4'h5);
    check("t4_busy_turn", busy, 1'b1);
    step();
    check("t4_busy_fall", busy, 1'b0);
    check("t4_rxv_fall", rx_valid, 1'b0);

    // T5: reset during DRIVE discards the transfer
    req = 4'b0001;
    bus = 4'h7;
    step();
    check("t5_en_drive", en, 4'b0001);
    req = 4'b0000;
    rst_n = 1'b0;
    step();
    check("t5_en", en, 4'b0000);
    check("t5_busy", busy, 1'b0);
    check("t5_rxv", rx_valid, 1'b0);
    check("t5_rxd", rx_data, 4'h0);
    check("t5_state", fsm_state, 2'd0);
    rst_n = 1'b1;
    step();
    check("t5_rxv_post", rx_valid, 1'b0);
    req = 4'b0011;
    step();
    check("t5_ptr_gid", grant_id, 2'd0);
    check("t5_ptr_en", en, 4'b0001);
    req = 4'b0000;
    step();
    step();
    step();

    // T6: HOLD=3 instance
    req3 = 4'b0010;
    bus3 = 4'hC;
    step();
    check("t6_gid", grant_id3, 2'd1);
    req3 = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) step();
      check("t6_en_high", en3, 4'b0010);
      check("t6_rxv_low", rx_valid3, 1'b0);
    end
    step();
    check("t6_en_off", en3, 4'b0000);
    check("t6_rxv", rx_valid3, 1'b1);
    check("t6_rxd", rx_data3, 4'hC);
    step();
    check("t6_busy_fall", busy3, 1'b0);
    check("t6_rxv_fall", rx_valid3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
